// File: rtl/hyp_rr_scheduler.sv
// -----------------------------------------------------------------------------
// hyp_rr_scheduler
// Round-robin front end for one shared, multi-cycle hypotenuse engine.
// The scheduler picks one requester, latches its x/y operands and pulses
// the engine start. It then waits for the engine's done pulse, with a
// watchdog as a bound, and returns the result on a valid/ready port tagged
// with the requester index. Only one job is in flight at any time.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req                   per-requester request level
//   req_x, req_y          packed operands, requester i at [i*DATA_W +: DATA_W]
//   gnt                   one-hot grant, one-cycle pulse
//   eng_start             engine start pulse
//   eng_x, eng_y          latched operands to the engine
//   eng_done, eng_result  engine result strobe and value
//   rsp_valid, rsp_ready  response handshake
//   rsp_id, rsp_data      served requester and its result (all-ones on abort)
//   rsp_timeout           high with rsp_valid when the watchdog aborted the job
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no job in flight, arbitrate among req
// ISSUE | one cycle: gnt and eng_start asserted for the winner
// WAIT  | engine busy, watchdog counting
// RESP  | response presented, held until rsp_ready
// -----------------------------------------------------------------------------
module hyp_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_x,
   input  logic [N_REQ*DATA_W-1:0] req_y,
   output logic [N_REQ-1:0]        gnt,
   output logic                    eng_start,
   output logic [DATA_W-1:0]       eng_x,
   output logic [DATA_W-1:0]       eng_y,
   input  logic                    eng_done,
   input  logic [DATA_W-1:0]       eng_result,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_timeout
);

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [WD_W-1:0]   wdog;

   logic              found;
   logic [ID_W-1:0]   win;
   logic [N_REQ-1:0]  win_oh;
   logic [DATA_W-1:0] win_x;
   logic [DATA_W-1:0] win_y;

   // Rotating priority without a modulo: first look above the last winner,
   // then wrap around to the indices at or below it.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (ID_W'(i) > ptr)) begin
            found = 1'b1;
            win   = ID_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (ID_W'(i) <= ptr)) begin
            found = 1'b1;
            win   = ID_W'(i);
         end
      end
   end

   always_comb begin
      win_x  = '0;
      win_y  = '0;
      win_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win == ID_W'(i)) begin
            win_x     = req_x[i*DATA_W +: DATA_W];
            win_y     = req_y[i*DATA_W +: DATA_W];
            win_oh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= ID_W'(N_REQ - 1);
         wdog        <= '0;
         gnt         <= '0;
         eng_start   <= 1'b0;
         eng_x       <= '0;
         eng_y       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  eng_x     <= win_x;
                  eng_y     <= win_y;
                  rsp_id    <= win;
                  ptr       <= win;
                  gnt       <= win_oh;
                  eng_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               gnt       <= '0;
               eng_start <= 1'b0;
               wdog      <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // A done arriving on the watchdog's last cycle still counts.
               if (eng_done) begin
                  rsp_data    <= eng_result;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                  rsp_data    <= '1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_timeout <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hyp_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hyp_rr_scheduler
// Directed scenarios followed by randomized jobs. A small engine model
// answers eng_start after a programmable delay (or never), and a reference
// model derives the expected winner from the last served requester and the
// expected result from an integer square root of the captured operands.
// -----------------------------------------------------------------------------
module tb_hyp_rr_scheduler;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_x, req_y;
   logic [N-1:0]  gnt;
   logic          eng_start;
   logic [DW-1:0] eng_x, eng_y;
   logic          eng_done;
   logic [DW-1:0] eng_result;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [DW-1:0] rsp_data;
   logic          rsp_timeout;

   hyp_rr_scheduler #(.N_REQ(N), .DATA_W(DW), .ID_W(2), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
      .gnt(gnt), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
      .eng_done(eng_done), .eng_result(eng_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int m_ptr    = N - 1;
   logic [DW-1:0] ox [N];
   logic [DW-1:0] oy [N];

   int  eng_delay = 3;
   bit  eng_on    = 1'b1;
   bit  late_done = 1'b0;
   int  e_cnt     = 0;
   logic [DW-1:0] e_x, e_y;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Next requester after the last one served, cyclically.
   function automatic int model_winner(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int c = (last + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_x[i*DW +: DW] = ox[i];
         req_y[i*DW +: DW] = oy[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_gnt", gnt, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_x", eng_x, 0);
      chk("rst_eng_y", eng_y, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      m_ptr = N - 1;
   endtask

   // One complete job starting from an IDLE negedge; ends at the IDLE
   // negedge following the response handshake.
   task automatic do_job(input logic [N-1:0] r, input logic [N-1:0] r_after,
                         input bit on, input int delay, input int hold,
                         input bit scramble, output int w);
      int cyc;
      logic [DW-1:0] ex, ey, exp_d;
      logic [N-1:0]  oh;
      req = r;
      pack();
      eng_on = on;
      eng_delay = delay;
      rsp_ready = 1'b0;
      w  = model_winner(r, m_ptr);
      ex = ox[w];
      ey = oy[w];
      oh = 4'b0001 << w;
      exp_d = on ? DW'(isqrt(int'(ex) * int'(ex) + int'(ey) * int'(ey))) : 8'hFF;
      @(negedge clk);
      chk("gnt", gnt, oh);
      chk("eng_start", eng_start, 1);
      chk("eng_x", eng_x, ex);
      chk("eng_y", eng_y, ey);
      chk("rsp_valid_issue", rsp_valid, 0);
      m_ptr = w;
      req = r_after;
      if (scramble) begin
         for (int i = 0; i < N; i++) begin
            ox[i] = DW'($urandom_range(0, 127));
            oy[i] = DW'($urandom_range(0, 127));
         end
         pack();
      end
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < TO + 20) begin
         @(negedge clk);
         cyc++;
         chk("gnt_busy", gnt, 0);
         chk("eng_start_busy", eng_start, 0);
      end
      chk("latency", cyc, on ? delay + 1 : TO + 1);
      chk("rsp_id", rsp_id, w);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_timeout", rsp_timeout, on ? 0 : 1);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_id", rsp_id, w);
         chk("hold_data", rsp_data, exp_d);
         chk("hold_gnt", gnt, 0);
         chk("hold_eng_start", eng_start, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_hs_valid", rsp_valid, 0);
      chk("post_hs_gnt", gnt, 0);
   endtask

   // Engine model: result = floor(sqrt(x^2+y^2)) of the operands seen at start.
   initial begin
      eng_done = 1'b0;
      eng_result = '0;
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         if (late_done) begin
            eng_done = 1'b1;
            eng_result = 8'h5A;
            late_done = 1'b0;
         end else if (e_cnt > 0) begin
            e_cnt--;
            if (e_cnt == 0) begin
               eng_done = 1'b1;
               eng_result = DW'(isqrt(int'(e_x) * int'(e_x) + int'(e_y) * int'(e_y)));
            end
         end
         if (eng_start === 1'b1 && eng_on) begin
            e_cnt = eng_delay;
            e_x = eng_x;
            e_y = eng_y;
         end
      end
   end

   initial begin
      int w;
      int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
      logic [N-1:0] r, ra;
      req = '0;
      req_x = '0;
      req_y = '0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         ox[i] = '0;
         oy[i] = '0;
      end
      @(negedge clk);
      do_reset();
      @(negedge clk);
      chk("idle_no_gnt", gnt, 0);

      // single job
      ox[0] = 8'd3; oy[0] = 8'd4;
      do_job(4'b0001, 4'b0000, 1'b1, 3, 0, 1'b0, w);

      // fairness with all requesters held
      do_reset();
      ox = '{8'd5, 8'd6, 8'd7, 8'd0};
      oy = '{8'd12, 8'd8, 8'd24, 8'd0};
      for (int j = 0; j < 6; j++) begin
         do_job(4'b1111, 4'b1111, 1'b1, 2 + j % 3, 0, 1'b0, w);
         chk("fair_order", rsp_id, exp_seq[j]);
      end

      // pointer rotation
      do_job(4'b0100, 4'b0000, 1'b1, 1, 0, 1'b0, w);
      do_job(4'b0101, 4'b0000, 1'b1, 2, 0, 1'b0, w);
      do_job(4'b0101, 4'b0000, 1'b1, 2, 0, 1'b0, w);

      // watchdog abort, then a stray done in IDLE
      ox[1] = 8'd1; oy[1] = 8'd1;
      do_job(4'b0010, 4'b0000, 1'b0, 1, 0, 1'b0, w);
      req = '0;
      late_done = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("late_done_valid", rsp_valid, 0);
         chk("late_done_gnt", gnt, 0);
         chk("late_done_start", eng_start, 0);
      end

      // backpressure with requester 3 waiting
      ox[0] = 8'd8; oy[0] = 8'd15;
      ox[3] = 8'd9; oy[3] = 8'd12;
      do_job(4'b0001, 4'b1000, 1'b1, 2, 5, 1'b0, w);
      do_job(4'b1000, 4'b0000, 1'b1, 2, 0, 1'b0, w);

      // reset while waiting on the engine
      req = 4'b0110;
      pack();
      eng_on = 1'b1;
      eng_delay = 6;
      w = model_winner(4'b0110, m_ptr);
      @(negedge clk);
      chk("rw_gnt", gnt, 4'b0001 << w);
      req = '0;
      repeat (2) @(negedge clk);
      do_reset();
      repeat (8) begin
         @(negedge clk);
         chk("dropped_no_rsp", rsp_valid, 0);
         chk("dropped_no_gnt", gnt, 0);
      end
      do_job(4'b1111, 4'b0000, 1'b1, 3, 0, 1'b0, w);
      chk("post_reset_id", rsp_id, 0);

      // randomized jobs
      for (int j = 0; j < 40; j++) begin
         for (int i = 0; i < N; i++) begin
            ox[i] = DW'($urandom_range(0, 127));
            oy[i] = DW'($urandom_range(0, 127));
         end
         r  = 4'($urandom_range(1, 15));
         ra = 4'($urandom_range(0, 15));
         do_job(r, ra, ($urandom_range(0, 7) != 0), $urandom_range(1, 6),
                $urandom_range(0, 3), 1'b1, w);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
